// File: rtl/muldiv_pkg.sv
// Shared types and constants for the MULT/DIV sequencer and its watchdog.
package muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        EXC   = 3'd4
    } state_e;

    localparam logic OP_MULT       = 1'b0;
    localparam logic OP_DIV        = 1'b1;

    localparam logic CAUSE_ZERO    = 1'b0;
    localparam logic CAUSE_TIMEOUT = 1'b1;

    // Completion strobe of whichever unit the latched op selected.
    function automatic logic sel_stop(input logic op_sel, input logic m_stop, input logic d_stop);
        logic r;
        if (op_sel == OP_DIV) begin
            r = d_stop;
        end else begin
            r = m_stop;
        end
        return r;
    endfunction

endpackage

// File: rtl/muldiv_timer.sv
// Watchdog counter: clear/enable, saturates at TIMEOUT, flags the last allowed RUN cycle.
module muldiv_timer #(
    parameter int TIMEOUT = 40
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);
    import muldiv_pkg::*;

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);
    localparam logic [W-1:0] LAST  = W'(TIMEOUT - 1);
    localparam logic [W-1:0] ONE   = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins over increment; hold once saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == LAST);

endmodule

// File: rtl/muldiv_sequencer.sv
// Launches one MULT/DIV per request, watches for completion under a watchdog,
// and steers/loads HI/LO. All outputs are flopped from the next-state decode.
module muldiv_sequencer #(
    parameter int TIMEOUT = 40
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic op,
    input  logic mult_stop,
    input  logic div_stop,
    input  logic div_zero,
    output logic mult_init,
    output logic div_init,
    output logic hi_sel,
    output logic lo_sel,
    output logic hi_load,
    output logic lo_load,
    output logic busy,
    output logic done,
    output logic div_zero_exc,
    output logic timeout_err
);
    import muldiv_pkg::*;

    state_e state_q, state_d;
    logic   op_q, op_d;
    logic   cause_q, cause_d;
    logic   timer_clr_s;
    logic   timer_en_s;
    logic   expire_s;
    logic   stop_s;

    logic   mult_init_q, mult_init_d;
    logic   div_init_q, div_init_d;
    logic   sel_q, sel_d;
    logic   load_q, load_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;
    logic   zero_exc_q, zero_exc_d;
    logic   tmo_err_q, tmo_err_d;

    muldiv_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (timer_clr_s),
        .en     (timer_en_s),
        .expire (expire_s)
    );

    assign stop_s     = sel_stop(op_q, mult_stop, div_stop);
    assign timer_en_s = (state_q == RUN);

    // Next-state logic; zero divisor beats a stop strobe, which beats the watchdog.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cause_d     = cause_q;
        timer_clr_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    op_d        = op;
                    timer_clr_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if ((op_q == OP_DIV) && div_zero) begin
                    state_d = EXC;
                    cause_d = CAUSE_ZERO;
                end else if (stop_s) begin
                    state_d = WRITE;
                end else if (expire_s) begin
                    state_d = EXC;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    state_d = RUN;
                end
            end
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            EXC:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode of the upcoming state so the flopped outputs line up with it.
    always_comb begin
        mult_init_d = 1'b0;
        div_init_d  = 1'b0;
        sel_d       = 1'b0;
        load_d      = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        zero_exc_d  = 1'b0;
        tmo_err_d   = 1'b0;
        if (state_d != IDLE) begin
            busy_d = 1'b1;
            sel_d  = op_d;
        end else begin
            busy_d = 1'b0;
            sel_d  = 1'b0;
        end
        if ((state_q == IDLE) && (state_d == RUN)) begin
            mult_init_d = (op_d == OP_MULT);
            div_init_d  = (op_d == OP_DIV);
        end else begin
            mult_init_d = 1'b0;
            div_init_d  = 1'b0;
        end
        load_d = (state_d == WRITE);
        done_d = (state_d == DONE);
        if (state_d == EXC) begin
            zero_exc_d = (cause_d == CAUSE_ZERO);
            tmo_err_d  = (cause_d == CAUSE_TIMEOUT);
        end else begin
            zero_exc_d = 1'b0;
            tmo_err_d  = 1'b0;
        end
    end

    // State, latched op/cause and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= 1'b0;
            cause_q     <= 1'b0;
            mult_init_q <= 1'b0;
            div_init_q  <= 1'b0;
            sel_q       <= 1'b0;
            load_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            zero_exc_q  <= 1'b0;
            tmo_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cause_q     <= cause_d;
            mult_init_q <= mult_init_d;
            div_init_q  <= div_init_d;
            sel_q       <= sel_d;
            load_q      <= load_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            zero_exc_q  <= zero_exc_d;
            tmo_err_q   <= tmo_err_d;
        end
    end

    assign mult_init    = mult_init_q;
    assign div_init     = div_init_q;
    assign hi_sel       = sel_q;
    assign lo_sel       = sel_q;
    assign hi_load      = load_q;
    assign lo_load      = load_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign div_zero_exc = zero_exc_q;
    assign timeout_err  = tmo_err_q;

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Sequences the multiplier and divider for MULT/DIV instructions on behalf of the main control unit. It launches one operation per request, waits for the unit's completion strobe under a watchdog, and steers and loads HI/LO. It reports completion, divide-by-zero and timeout back to control. It sits between `Unid_Control` and the `mult`/`div` units and the `high_`/`low_` registers with their source muxes.

## Interface
- `TIMEOUT`, default 40: maximum RUN cycles allowed without a completion strobe before a timeout is raised. Legal range is 2..255.
- `clk` input 1: system clock. All state changes on the rising edge.
- `reset` input 1: asynchronous, active-high. Forces IDLE and drives every registered output to 0.
- `start` input 1: one-cycle operation request from control. Sampled only in IDLE.
- `op` input 1: 0 = MULT, 1 = DIV. Sampled with `start`.
- `mult_stop` input 1: multiplier completion strobe.
- `div_stop` input 1: divider completion strobe.
- `div_zero` input 1: divider reports a zero divisor.
- `mult_init` output 1: one-cycle launch pulse to the multiplier.
- `div_init` output 1: one-cycle launch pulse to the divider.
- `hi_sel` output 1: HI source mux select. 0 = multiplier, 1 = divider.
- `lo_sel` output 1: LO source mux select. 0 = multiplier, 1 = divider.
- `hi_load` output 1: HI register load enable.
- `lo_load` output 1: LO register load enable.
- `busy` output 1: high from the cycle after an accepted `start` until the state returns to IDLE. Control stalls while it is high.
- `done` output 1: one-cycle pulse, HI/LO were written.
- `div_zero_exc` output 1: one-cycle pulse, a division aborted on a zero divisor.
- `timeout_err` output 1: one-cycle pulse, the watchdog expired.

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: the selected unit is operating.
  - WRITE: HI/LO are loaded.
  - DONE: completion is reported.
  - EXC: an exception is reported.
- IDLE:
  - `start`=1 latches `op` into `op_q`, clears the watchdog counter and moves to RUN.
  - `start`=0 stays in IDLE.
- RUN, first cycle: `mult_init` (if `op_q`=0) or `div_init` (if `op_q`=1) is 1. It is 0 on every later cycle.
- RUN, each cycle: the watchdog counter increments, saturating at `TIMEOUT`. Transitions are evaluated in this priority order:
  1. `op_q`=1 and `div_zero`=1: go to EXC with cause ZERO.
  2. The selected unit's stop strobe is 1: go to WRITE.
  3. The counter equals `TIMEOUT`-1 and no stop strobe: go to EXC with cause TIMEOUT.
  4. Otherwise: stay in RUN.
- The non-selected unit's stop strobe is ignored. `mult_stop` in a DIV run has no effect.
- WRITE, one cycle:
  - `hi_load`=`lo_load`=1.
  - `hi_sel`=`lo_sel`=`op_q`.
  - Then go to DONE.
- DONE, one cycle: `done`=1, then go to IDLE.
- EXC, one cycle:
  - `div_zero_exc`=1 or `timeout_err`=1 according to the cause.
  - No HI/LO load.
  - Then go to IDLE.
- `hi_sel`/`lo_sel` hold `op_q` in every non-IDLE state. They are 0 in IDLE.
- `start` outside IDLE is ignored. It is not queued.
- Reset mid-operation:
  - Returns to IDLE immediately and zeroes the counter and `op_q`.
  - Any launched unit is left to the unit's own reset.

## Timing
- Every output is a registered or a pure decode of registered state. There are no combinational paths from inputs to outputs.
- Let `start`=1 be sampled at edge 0:
  - RUN and the init pulse appear after edge 0, with `busy`=1.
  - A stop strobe sampled at edge k moves to WRITE after edge k.
  - DONE follows after edge k+1.
  - IDLE follows after edge k+2, and `busy` falls then.
- Minimum latency from `start` to `done` is 3 cycles, when the stop strobe arrives in the first RUN cycle.
- A new `start` is accepted in the first IDLE cycle after DONE/EXC. There is a 1-cycle gap.
- Timeout: EXC is entered after exactly `TIMEOUT` RUN cycles with no stop strobe.
- Stop strobe and timeout in the same cycle: the stop strobe wins.
- `div_stop` and `div_zero` in the same cycle: `div_zero` wins.

## Structure
- `muldiv_pkg`:
  - State enum: IDLE, RUN, WRITE, DONE, EXC.
  - Op constants: OP_MULT=0, OP_DIV=1.
  - Cause constants: CAUSE_ZERO, CAUSE_TIMEOUT.
- Sub-module `muldiv_timer`:
  - Clear/enable watchdog counter, width $clog2(`TIMEOUT`+1).
  - Outputs `expire` when the count equals `TIMEOUT`-1.
  - Same clock and asynchronous reset.
- The FSM and output decode live in `muldiv_sequencer`.

## Test plan
- Reset held 3 cycles, then released: all outputs are 0 and the state is IDLE. Reset asserted mid-RUN: outputs are 0 within the same cycle and no `done` follows.
- `start`=1 with `op`=0, and `mult_stop` 33 cycles into RUN:
  - `mult_init` pulses once.
  - WRITE has `hi_load`=`lo_load`=1 and `hi_sel`=`lo_sel`=0.
  - `done` pulses 2 cycles after the stop strobe.
  - `busy` covers the whole operation.
- `op`=1 with `div_stop` after 5 cycles: `div_init` pulses once, `hi_sel`=`lo_sel`=1 during WRITE, and `done` pulses. A stray `mult_stop` during RUN is ignored.
- `op`=1 with `div_zero` and `div_stop` in the same cycle: `div_zero_exc` pulses, there is no `hi_load`/`lo_load`, and `done` never asserts.
- `TIMEOUT`=8 with no stop strobe: `timeout_err` pulses after exactly 8 RUN cycles and the state returns to IDLE. Repeat with `mult_stop` in the 8th cycle: `done` instead of `timeout_err`.
- `start` pulsed during RUN and in the DONE cycle: both ignored. `start` on the first IDLE cycle after DONE is accepted.
